bank_wr_queue: RTL and testbench
================================

Name: bank_wr_queue

Overview:
- Write-side front end for the six-bank 64-bit register memory.
- Accepts valid/ready write requests, buffers them in a small FIFO and range-checks each address against its bank size.
- Drives the memory's write port (t_wa, d) with an explicit write enable.
- Out-of-range writes are dropped and counted instead of aliasing into a bank.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AW, 9, write address width: bits [8:6] select the bank, bits [5:0] are the index.
- DW, 64, data width.
- BANK0_ENTRIES, 48, valid index range of bank 0, using index bits [5:0].
- BANKN_ENTRIES, 24, valid index range of banks 1-5, using index bits [4:0].
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  clock.
- reset_l  in  1  asynchronous active-low reset.
- in_valid  in  1  write request valid.
- in_ready  out  1  queue can accept a request.
- in_addr  in  AW  request address {bank[2:0], idx[5:0]}.
- in_data  in  DW  request data.
- wr_stall  in  1  downstream cannot take a write this cycle.
- wr_en  out  1  write strobe to the memory.
- t_wa  out  AW  write address to the memory.
- d  out  DW  write data to the memory.
- oob_pulse  out  1  one-cycle pulse when an out-of-range entry is dropped.
- drop_cnt  out  CNT_W  saturating count of dropped entries.
- init_done  out  1  high once the block is in RUN.

Behaviour:
- Reset (reset_l low, asynchronous) sets:
  - wr_en=0, t_wa=0, d=0, oob_pulse=0, drop_cnt=0, FIFO empty.
  - in_ready=0, init_done=0.
  - FSM to INIT (macro present) or RUN (macro absent).
- Reset asserted mid-operation discards all queued entries. Nothing is written after reset asserts.
- Push occurs when in_valid && in_ready.
  - in_ready = !full && state==RUN, computed from registered state.
  - A pop in the same cycle does not raise in_ready when the FIFO is full.
- Pop occurs when the FIFO is non-empty, state==RUN and !wr_stall.
- There is no bypass path.
  - A pushed entry reaches the head the next cycle and can pop that cycle.
  - Minimum latency from push to wr_en is 2 cycles.
- Push and pop in the same cycle are legal at any occupancy between empty and full; occupancy is unchanged.
- Pointer width is log2(DEPTH)+1; full/empty are derived from the MSB wrap comparison.
- Range check on the head entry, with bank = addr[8:6]:
  - bank 0 is out of range when addr[5:0] >= BANK0_ENTRIES.
  - banks 1-7 are out of range when addr[4:0] >= BANKN_ENTRIES. addr[5] is ignored.
  - Bank codes 6 and 7 are legal aliases of bank 5 and pass through unchanged.
- On pop of an in-range entry, the next cycle has wr_en=1 with t_wa/d equal to the entry.
- On pop of an out-of-range entry, the next cycle has wr_en=0 and oob_pulse=1.
  - drop_cnt increments and saturates at all-ones.
  - t_wa/d hold their previous values.
- With no pop, wr_en=0 and t_wa/d hold.
- wr_stall only gates the pop. A strobe already registered is still presented for its one cycle.
- States: INIT, then RUN. RUN is terminal until reset.

Optional Feature:
- Macro: BANK_WR_QUEUE_CLEAR_SWEEP_EN.
- Present: reset enters INIT, which performs a zero-fill sweep of every legal address.
  - Order: bank 0 idx 0..47, then banks 1..5 idx 0..23, giving 168 writes.
  - Each write has wr_en=1, d=0, t_wa={bank,idx}.
  - The sweep counter advances only on cycles with !wr_stall.
  - in_ready=0 throughout the sweep.
  - After the last write, state goes to RUN and init_done rises the following cycle.
  - The sweep never touches drop_cnt.
- Absent: no INIT state. The first cycle after reset release is RUN, with init_done=1 and in_ready=1.

Decomposition:
- Shared package bank_mem_pkg holds:
  - constants NUM_BANKS=6, BANK0_ENTRIES, BANKN_ENTRIES, AW, DW;
  - a bank_sel_t typedef (3 bits);
  - function addr_in_range(addr) returning the legality bit.
  - The same package serves the read-side decoder.
- One sub-module, bank_wr_fifo: a generic DEPTH x (AW+DW) synchronous FIFO with push/pop/full/empty.
- The range check, FSM, sweep counter and output register stay in the top.

Test Plan:
- Macro absent; push addr 9'h005 data 64'h1111 with no stall -> wr_en=1 with t_wa=9'h005, d=64'h1111 exactly 2 cycles after push; drop_cnt=0.
- Push 9'h030 (bank 0, idx 48) then 9'h058 (bank 1, idx 24) -> two oob_pulse cycles, wr_en never high, drop_cnt=2.
- Push 9'h06A (bank 1, addr[5]=1, idx[4:0]=10) and 9'h1C3 (bank 7) -> both written unchanged with wr_en=1.
- Hold wr_stall=1 and push 5 requests with DEPTH=4 -> in_ready low after the 4th; 5th accepted only after stall release; the writes come out in order with no loss or duplication.
- Macro present; release reset with no stall -> 168 consecutive wr_en cycles.
  - First write t_wa=9'h000, last t_wa=9'h157; d=0 throughout.
  - init_done rises the following cycle; in_ready=0 until then.
  - Repeat with wr_stall toggling every other cycle -> still exactly 168 writes.
- Assert reset_l low with 3 entries queued and wr_en high -> wr_en drops asynchronously; no queued entry is written after release.

Source files
------------

// File: rtl/bank_mem_pkg.sv
// Shared definitions for the six-bank 64-bit register memory.
// Used by the write-side queue and the read-side decoder.
package bank_mem_pkg;

   localparam int NUM_BANKS     = 6;
   localparam int BANK0_ENTRIES = 48;
   localparam int BANKN_ENTRIES = 24;
   localparam int AW            = 9;
   localparam int DW            = 64;

   typedef logic [2:0] bank_sel_t;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } wq_state_t;

   // Bank 0 uses the full six index bits. Every other bank code uses only
   // idx[4:0]; codes 6 and 7 alias bank 5 and follow the same rule.
   function automatic logic addr_in_range(input logic [AW-1:0] addr,
                                          input int b0_entries = BANK0_ENTRIES,
                                          input int bn_entries = BANKN_ENTRIES);
      bank_sel_t bank;
      int        idx;
      logic      ok;
      bank = addr[AW-1:AW-3];
      if (bank == 3'd0) begin
         idx = int'(addr[5:0]);
         ok  = (idx < b0_entries);
      end else begin
         idx = int'(addr[4:0]);
         ok  = (idx < bn_entries);
      end
      return ok;
   endfunction

endpackage

// File: rtl/bank_wr_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with push/pop/full/empty.
// Pointers carry one extra wrap bit so full and empty are told apart by
// comparing the MSBs. The head entry is always presented on head_data.
module bank_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 73
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH) + 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem_q[rd_ptr_q[PW-2:0]];

   // Advance pointers and write the pushed entry into its slot.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (do_push) begin
         mem_d[wr_ptr_q[PW-2:0]] = push_data;
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: only slots between the pointers are ever read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

endmodule

// File: rtl/bank_wr_queue.sv
// Write-side front end for the six-bank register memory: buffers write
// requests, range-checks the head entry and drives the memory write port.
// Out-of-range entries are dropped and counted rather than aliased.
// Optional: BANK_WR_QUEUE_CLEAR_SWEEP_EN adds an INIT state that zero-fills
// every legal address after reset before requests are accepted.
module bank_wr_queue
   import bank_mem_pkg::*;
#(
   parameter int DEPTH         = 4,
   parameter int AW            = 9,
   parameter int DW            = 64,
   parameter int BANK0_ENTRIES = 48,
   parameter int BANKN_ENTRIES = 24,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset_l,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [AW-1:0]    in_addr,
   input  logic [DW-1:0]    in_data,
   input  logic             wr_stall,
   output logic             wr_en,
   output logic [AW-1:0]    t_wa,
   output logic [DW-1:0]    d,
   output logic             oob_pulse,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             init_done
);

   localparam int FW = AW + DW;

   wq_state_t        state_q, state_d;
   logic             wr_en_q, wr_en_d;
   logic [AW-1:0]    t_wa_q, t_wa_d;
   logic [DW-1:0]    d_q, d_d;
   logic             oob_q, oob_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             init_done_q, init_done_d;

`ifdef BANK_WR_QUEUE_CLEAR_SWEEP_EN
   bank_sel_t        sw_bank_q, sw_bank_d;
   logic [5:0]       sw_idx_q, sw_idx_d;
   logic             sw_bank_end;
`endif

   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic [FW-1:0]    head;
   logic [AW-1:0]    head_addr;
   logic [DW-1:0]    head_data;
   logic             head_ok;

   // init_done_q only rises after a full cycle in RUN, so it also keeps
   // in_ready low during reset and through the final sweep write.
   assign in_ready  = !fifo_full && init_done_q;
   assign push      = in_valid && in_ready;
   assign pop       = !fifo_empty && (state_q == ST_RUN) && !wr_stall;
   assign head_addr = head[FW-1:DW];
   assign head_data = head[DW-1:0];
   assign head_ok   = addr_in_range(head_addr, BANK0_ENTRIES, BANKN_ENTRIES);

   assign wr_en     = wr_en_q;
   assign t_wa      = t_wa_q;
   assign d         = d_q;
   assign oob_pulse = oob_q;
   assign drop_cnt  = drop_cnt_q;
   assign init_done = init_done_q;

   bank_wr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset_l),
      .push      (push),
      .push_data ({in_addr, in_data}),
      .pop       (pop),
      .head_data (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Next-state: sweep writes in INIT, range-checked pops in RUN.
   always_comb begin
      state_d     = state_q;
      wr_en_d     = 1'b0;
      t_wa_d      = t_wa_q;
      d_d         = d_q;
      oob_d       = 1'b0;
      drop_cnt_d  = drop_cnt_q;
      init_done_d = (state_q == ST_RUN);
`ifdef BANK_WR_QUEUE_CLEAR_SWEEP_EN
      sw_bank_d   = sw_bank_q;
      sw_idx_d    = sw_idx_q;
      sw_bank_end = (sw_bank_q == 3'd0) ? (sw_idx_q == 6'(BANK0_ENTRIES - 1))
                                        : (sw_idx_q == 6'(BANKN_ENTRIES - 1));
`endif
      if (state_q == ST_RUN) begin
         if (pop) begin
            if (head_ok) begin
               wr_en_d = 1'b1;
               t_wa_d  = head_addr;
               d_d     = head_data;
            end else begin
               oob_d = 1'b1;
               if (drop_cnt_q != '1) begin
                  drop_cnt_d = drop_cnt_q + 1'b1;
               end
            end
         end
      end
`ifdef BANK_WR_QUEUE_CLEAR_SWEEP_EN
      else if (!wr_stall) begin
         wr_en_d = 1'b1;
         t_wa_d  = AW'({sw_bank_q, sw_idx_q});
         d_d     = '0;
         if (sw_bank_end) begin
            sw_idx_d = '0;
            if (sw_bank_q == 3'(NUM_BANKS - 1)) begin
               state_d = ST_RUN;
            end else begin
               sw_bank_d = sw_bank_q + 1'b1;
            end
         end else begin
            sw_idx_d = sw_idx_q + 1'b1;
         end
      end
`endif
   end

   // State, sweep counter and output registers.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
`ifdef BANK_WR_QUEUE_CLEAR_SWEEP_EN
         state_q     <= ST_INIT;
         sw_bank_q   <= '0;
         sw_idx_q    <= '0;
`else
         state_q     <= ST_RUN;
`endif
         wr_en_q     <= 1'b0;
         t_wa_q      <= '0;
         d_q         <= '0;
         oob_q       <= 1'b0;
         drop_cnt_q  <= '0;
         init_done_q <= 1'b0;
      end else begin
`ifdef BANK_WR_QUEUE_CLEAR_SWEEP_EN
         sw_bank_q   <= sw_bank_d;
         sw_idx_q    <= sw_idx_d;
`endif
         state_q     <= state_d;
         wr_en_q     <= wr_en_d;
         t_wa_q      <= t_wa_d;
         d_q         <= d_d;
         oob_q       <= oob_d;
         drop_cnt_q  <= drop_cnt_d;
         init_done_q <= init_done_d;
      end
   end

endmodule

// File: tb/tb_bank_wr_queue.sv
// Testbench for bank_wr_queue. Inputs change on the falling edge and
// outputs are sampled on the falling edge. A monitor collects every write
// strobe and drop pulse; each test compares that stream with a reference
// queue built from the address legality rules.
module tb_bank_wr_queue;

   localparam int AW    = 9;
   localparam int DW    = 64;
   localparam int CNT_W = 16;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset_l = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [AW-1:0]    in_addr = '0;
   logic [DW-1:0]    in_data = '0;
   logic             wr_stall = 1'b0;
   logic             wr_en;
   logic [AW-1:0]    t_wa;
   logic [DW-1:0]    d;
   logic             oob_pulse;
   logic [CNT_W-1:0] drop_cnt;
   logic             init_done;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic          is_wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ev_t;

   ev_t exp_q[$];
   ev_t obs_q[$];
   int  exp_drops = 0;
   bit  mon_en = 1'b0;
   bit  rnd_run = 1'b0;

   always #5 clk = ~clk;

   bank_wr_queue #(
      .DEPTH         (DEPTH),
      .AW            (AW),
      .DW            (DW),
      .BANK0_ENTRIES (48),
      .BANKN_ENTRIES (24),
      .CNT_W         (CNT_W)
   ) dut (
      .clk       (clk),
      .reset_l   (reset_l),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .wr_stall  (wr_stall),
      .wr_en     (wr_en),
      .t_wa      (t_wa),
      .d         (d),
      .oob_pulse (oob_pulse),
      .drop_cnt  (drop_cnt),
      .init_done (init_done)
   );

   // Record each presented write and each drop pulse (drops carry no payload).
   always @(negedge clk) begin
      if (mon_en) begin
         if (wr_en)     obs_q.push_back('{is_wr: 1'b1, addr: t_wa, data: d});
         if (oob_pulse) obs_q.push_back('{is_wr: 1'b0, addr: '0, data: '0});
      end
   end

   // Legality from the bank map: bank 0 holds 48 entries, all other codes
   // hold 24 entries addressed by the low five index bits.
   function automatic bit model_legal(input logic [AW-1:0] a);
      int bank;
      int idx;
      bank = int'(a) / 64;
      idx  = int'(a) % 64;
      if (bank == 0) return idx < 48;
      return (idx % 32) < 24;
   endfunction

   task automatic model_accept(input logic [AW-1:0] a, input logic [DW-1:0] dat);
      if (model_legal(a)) begin
         exp_q.push_back('{is_wr: 1'b1, addr: a, data: dat});
      end else begin
         exp_q.push_back('{is_wr: 1'b0, addr: '0, data: '0});
         exp_drops++;
      end
   endtask

   // Offer one request starting at a falling edge; returns at the falling
   // edge after it was taken, or flags a timeout.
   task automatic push_req(input logic [AW-1:0] a, input logic [DW-1:0] dat);
      int waited;
      waited   = 0;
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = dat;
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL push_timeout addr=%h in_ready=%b required 1", a, in_ready);
      end else begin
         model_accept(a, dat);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      int waited;
      mon_en   = 1'b0;
      in_valid = 1'b0;
      wr_stall = 1'b0;
      reset_l  = 1'b0;
      repeat (2) @(negedge clk);
      reset_l = 1'b1;
`ifdef BANK_WR_QUEUE_CLEAR_SWEEP_EN
      waited = 0;
      while (init_done !== 1'b1 && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (init_done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_init_timeout init_done=%b required 1", init_done);
      end
`else
      waited = 0;
      @(negedge clk);
`endif
      exp_drops = 0;
      exp_q.delete();
      obs_q.delete();
      mon_en = 1'b1;
   endtask

   task automatic test_reset();
      int waited;
      reset_l  = 1'b0;
      in_valid = 1'b0;
      wr_stall = 1'b0;
      repeat (3) @(negedge clk);
      checks += 7;
      if (wr_en !== 1'b0)      begin errors++; $display("[TB] FAIL rst_wr_en got %b want 0", wr_en); end
      if (t_wa !== '0)         begin errors++; $display("[TB] FAIL rst_t_wa got %h want 0", t_wa); end
      if (d !== '0)            begin errors++; $display("[TB] FAIL rst_d got %h want 0", d); end
      if (oob_pulse !== 1'b0)  begin errors++; $display("[TB] FAIL rst_oob got %b want 0", oob_pulse); end
      if (drop_cnt !== '0)     begin errors++; $display("[TB] FAIL rst_drop got %0d want 0", drop_cnt); end
      if (in_ready !== 1'b0)   begin errors++; $display("[TB] FAIL rst_in_ready got %b want 0", in_ready); end
      if (init_done !== 1'b0)  begin errors++; $display("[TB] FAIL rst_init_done got %b want 0", init_done); end
      reset_l = 1'b1;
      @(negedge clk);
      checks += 2;
`ifdef BANK_WR_QUEUE_CLEAR_SWEEP_EN
      if (init_done !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rel_ready got init_done=%b in_ready=%b want 0/0", init_done, in_ready);
      end
      if (wr_en !== 1'b1 || t_wa !== 9'h000) begin
         errors++;
         $display("[TB] FAIL rel_first_sweep got wr_en=%b t_wa=%h want 1/000", wr_en, t_wa);
      end
      waited = 0;
      while (init_done !== 1'b1 && waited < 500) begin
         @(negedge clk);
         waited++;
      end
`else
      waited = 0;
      if (init_done !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rel_ready got init_done=%b in_ready=%b want 1/1", init_done, in_ready);
      end
      if (wr_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rel_wr_en got %b want 0", wr_en);
      end
`endif
   endtask

`ifdef BANK_WR_QUEUE_CLEAR_SWEEP_EN
   // Zero-fill sweep: 168 writes in bank/index order, optionally with
   // wr_stall toggling every other cycle.
   task automatic test_sweep(input bit toggle);
      logic [AW-1:0] exp_addr[$];
      logic [AW-1:0] first_a;
      logic [AW-1:0] last_a;
      int cyc, nwr, first_cyc, last_cyc, rise;
      int addr_bad, data_bad, ready_bad;
      for (int b = 0; b < 6; b++) begin
         for (int i = 0; i < ((b == 0) ? 48 : 24); i++) begin
            exp_addr.push_back(AW'(b * 64 + i));
         end
      end
      mon_en   = 1'b0;
      in_valid = 1'b0;
      wr_stall = 1'b0;
      reset_l  = 1'b0;
      repeat (2) @(negedge clk);
      reset_l = 1'b1;
      cyc = 0; nwr = 0; first_cyc = -1; last_cyc = -1; rise = -1;
      addr_bad = 0; data_bad = 0; ready_bad = 0;
      first_a = '1; last_a = '1;
      while (cyc < 1000 && rise < 0) begin
         wr_stall = toggle && (cyc % 2 == 1);
         @(negedge clk);
         cyc++;
         if (wr_en) begin
            if (nwr >= 168 || t_wa !== exp_addr[nwr]) addr_bad++;
            if (d !== '0) data_bad++;
            if (nwr == 0) begin first_a = t_wa; first_cyc = cyc; end
            last_a   = t_wa;
            last_cyc = cyc;
            nwr++;
         end
         if (init_done) rise = cyc;
         else if (in_ready) ready_bad++;
      end
      wr_stall = 1'b0;
      checks += 8;
      if (nwr != 168)       begin errors++; $display("[TB] FAIL sweep_count t=%0d got %0d want 168", toggle, nwr); end
      if (first_a !== 9'h000) begin errors++; $display("[TB] FAIL sweep_first got %h want 000", first_a); end
      if (last_a !== 9'h157)  begin errors++; $display("[TB] FAIL sweep_last got %h want 157", last_a); end
      if (addr_bad != 0)    begin errors++; $display("[TB] FAIL sweep_order bad=%0d want 0", addr_bad); end
      if (data_bad != 0)    begin errors++; $display("[TB] FAIL sweep_data bad=%0d want 0", data_bad); end
      if (ready_bad != 0)   begin errors++; $display("[TB] FAIL sweep_in_ready high=%0d want 0", ready_bad); end
      if (rise != last_cyc + 1) begin errors++; $display("[TB] FAIL sweep_init_rise got %0d want %0d", rise, last_cyc + 1); end
      if (drop_cnt !== '0)  begin errors++; $display("[TB] FAIL sweep_drop got %0d want 0", drop_cnt); end
      if (!toggle) begin
         checks++;
         if (last_cyc - first_cyc != 167) begin
            errors++;
            $display("[TB] FAIL sweep_consecutive span got %0d want 167", last_cyc - first_cyc);
         end
      end
   endtask
`endif

   // One in-range write: strobe appears exactly two cycles after the push.
   task automatic test_single_write();
      in_valid = 1'b1;
      in_addr  = 9'h005;
      in_data  = 64'h1111;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready got %b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL single_early got wr_en=%b want 0", wr_en); end
      @(negedge clk);
      checks += 3;
      if (wr_en !== 1'b1)        begin errors++; $display("[TB] FAIL single_wr_en got %b want 1", wr_en); end
      if (t_wa !== 9'h005)       begin errors++; $display("[TB] FAIL single_t_wa got %h want 005", t_wa); end
      if (d !== 64'h1111)        begin errors++; $display("[TB] FAIL single_d got %h want 1111", d); end
      @(negedge clk);
      checks += 2;
      if (wr_en !== 1'b0)        begin errors++; $display("[TB] FAIL single_one_cycle got %b want 0", wr_en); end
      if (drop_cnt !== '0)       begin errors++; $display("[TB] FAIL single_drop got %0d want 0", drop_cnt); end
      exp_q.delete();
      obs_q.delete();
   endtask

   // Boundary indices just past the end of bank 0 and bank 1 are dropped.
   task automatic test_oob();
      exp_q.delete();
      obs_q.delete();
      push_req(9'h030, 64'hAAAA);
      push_req(9'h058, 64'hBBBB);
      repeat (8) @(negedge clk);
      checks += 3;
      if (obs_q.size() != 2) begin
         errors++;
         $display("[TB] FAIL oob_events got %0d want 2", obs_q.size());
      end else if (obs_q[0].is_wr !== 1'b0 || obs_q[1].is_wr !== 1'b0) begin
         errors++;
         $display("[TB] FAIL oob_kind got %b%b want 00", obs_q[0].is_wr, obs_q[1].is_wr);
      end
      if (drop_cnt !== CNT_W'(exp_drops)) begin
         errors++;
         $display("[TB] FAIL oob_drop_cnt got %0d want %0d", drop_cnt, exp_drops);
      end
      if (t_wa !== 9'h005 || d !== 64'h1111) begin
         errors++;
         $display("[TB] FAIL oob_hold got %h/%h want 005/1111", t_wa, d);
      end
   endtask

   // addr[5] ignored outside bank 0; bank code 7 passes through unchanged.
   task automatic test_alias();
      exp_q.delete();
      obs_q.delete();
      push_req(9'h06A, 64'hCAFE_0001);
      push_req(9'h1C3, 64'hCAFE_0002);
      repeat (8) @(negedge clk);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("[TB] FAIL alias_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL alias_ev%0d got wr=%b %h %h want wr=%b %h %h", i,
                     obs_q[i].is_wr, obs_q[i].addr, obs_q[i].data,
                     exp_q[i].is_wr, exp_q[i].addr, exp_q[i].data);
         end
      end
   endtask

   // Fill under stall, confirm back-pressure, then drain in order.
   task automatic test_backpressure();
      logic [AW-1:0] a5;
      logic [DW-1:0] d5;
      exp_q.delete();
      obs_q.delete();
      wr_stall = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         push_req(AW'($urandom_range(0, 511)), {$urandom, $urandom});
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full got in_ready=%b want 0", in_ready); end
      a5 = AW'($urandom_range(0, 511));
      d5 = {$urandom, $urandom};
      in_valid = 1'b1;
      in_addr  = a5;
      in_data  = d5;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold got in_ready=%b want 0", in_ready); end
      end
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL bp_stalled_out got %0d events want 0", obs_q.size()); end
      wr_stall = 1'b0;
      push_req(a5, d5);
      repeat (10) @(negedge clk);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("[TB] FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL bp_ev%0d got wr=%b %h %h want wr=%b %h %h", i,
                     obs_q[i].is_wr, obs_q[i].addr, obs_q[i].data,
                     exp_q[i].is_wr, exp_q[i].addr, exp_q[i].data);
         end
      end
   endtask

   // Random addresses and data with random downstream stalls.
   task automatic test_random();
      exp_q.delete();
      obs_q.delete();
      rnd_run = 1'b1;
      fork
         begin
            while (rnd_run) begin
               @(negedge clk);
               if (rnd_run) wr_stall = ($urandom_range(0, 3) == 0);
            end
         end
      join_none
      for (int n = 0; n < 40; n++) begin
         push_req(AW'($urandom_range(0, 511)), {$urandom, $urandom});
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rnd_run = 1'b0;
      @(negedge clk);
      wr_stall = 1'b0;
      repeat (20) @(negedge clk);
      checks += 2;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("[TB] FAIL rnd_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      if (drop_cnt !== CNT_W'(exp_drops)) begin
         errors++;
         $display("[TB] FAIL rnd_drop_cnt got %0d want %0d", drop_cnt, exp_drops);
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("[TB] FAIL rnd_ev%0d got wr=%b %h %h want wr=%b %h %h", i,
                     obs_q[i].is_wr, obs_q[i].addr, obs_q[i].data,
                     exp_q[i].is_wr, exp_q[i].addr, exp_q[i].data);
         end
      end
   endtask

   // Reset with three entries queued and a write on the port.
   task automatic test_reset_mid();
      exp_q.delete();
      obs_q.delete();
      wr_stall = 1'b1;
      push_req(9'h001, 64'h0101);
      push_req(9'h002, 64'h0202);
      push_req(9'h003, 64'h0303);
      push_req(9'h004, 64'h0404);
      wr_stall = 1'b0;
      @(negedge clk);
      wr_stall = 1'b1;
      checks++;
      if (wr_en !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_wr_en got %b want 1", wr_en); end
      #2 reset_l = 1'b0;
      #1;
      checks += 2;
      if (wr_en !== 1'b0)    begin errors++; $display("[TB] FAIL mid_async_wr_en got %b want 0", wr_en); end
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_ready got %b want 0", in_ready); end
      @(negedge clk);
      do_reset();
      repeat (12) @(negedge clk);
      checks += 2;
      if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL mid_leak got %0d events want 0", obs_q.size()); end
      if (drop_cnt !== '0)   begin errors++; $display("[TB] FAIL mid_drop got %0d want 0", drop_cnt); end
   endtask

   initial begin
      test_reset();
`ifdef BANK_WR_QUEUE_CLEAR_SWEEP_EN
      test_sweep(1'b0);
      test_sweep(1'b1);
`endif
      do_reset();
      test_single_write();
      test_oob();
      test_alias();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time limit so the bench always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout reached without finishing");
      $fatal(1, "[TB] timeout");
   end

endmodule
